pool_frame_collector: RTL

POOL_FRAME_COLLECTOR -- requirements
Module: pool_frame_collector

---
 rtl/pool_frame_collector_pkg.sv | 11 +
 rtl/pool_frame_collector_index.sv | 29 ++
 rtl/pool_frame_collector.sv | 100 ++++++++++
 3 files changed

// File: rtl/pool_frame_collector_pkg.sv
// Shared constants for the pooling stages: collector FSM encoding and frame counter width.
package pool_frame_collector_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } coll_state_t;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/pool_frame_collector_index.sv
// Pixel write-address counter for the frame collector, with terminal-count flag at the last pixel.
module pixel_index_counter #(
  parameter int NPIX  = 16,
  parameter int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_tc
);

  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign o_idx = r_idx;
  assign o_tc  = (r_idx == IDX_W'(NPIX - 1));

endmodule

// File: rtl/pool_frame_collector.sv
// Collects a row-major pixel stream into one packed frame and hands it to the 2x2 max-pool stage.
module pool_frame_collector
  import pool_frame_collector_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int W         = 46,
  parameter int H         = 46
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_BITS-1:0]         in_data,
  input  logic                         in_last,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [0:H*W*DATA_BITS-1]     frame_data,
  output logic                         len_err,
  output logic [FRAME_CNT_W-1:0]       frame_count
);

  localparam int NPIX  = H * W;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  coll_state_t              r_state;
  logic                     r_in_ready;
  logic                     r_frame_valid;
  logic                     r_len_err;
  logic [FRAME_CNT_W-1:0]   r_frame_count;
  logic [0:NPIX*DATA_BITS-1] r_frame_data;

  logic [IDX_W-1:0] w_idx;
  logic             w_tc;
  logic             w_accept;
  logic             w_idx_clr;

  assign w_accept  = in_valid && (r_state == FILL);
  // A short frame (in_last before the end) restarts the fill at word 0.
  assign w_idx_clr = w_accept && (w_tc || in_last);

  pixel_index_counter #(
    .NPIX  (NPIX),
    .IDX_W (IDX_W)
  ) u_idx (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_idx_clr),
    .i_inc (w_accept),
    .o_idx (w_idx),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FILL;
      r_in_ready    <= 1'b1;
      r_frame_valid <= 1'b0;
      r_len_err     <= 1'b0;
      r_frame_count <= '0;
      r_frame_data  <= '0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        FILL: begin
          if (in_valid) begin
            r_frame_data[int'(w_idx)*DATA_BITS +: DATA_BITS] <= in_data;
            if (w_tc) begin
              r_state       <= HOLD;
              r_in_ready    <= 1'b0;
              r_frame_valid <= 1'b1;
              r_len_err     <= ~in_last;
            end else if (in_last) begin
              r_len_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (frame_ready) begin
            r_state       <= FILL;
            r_in_ready    <= 1'b1;
            r_frame_valid <= 1'b0;
            r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
          end
        end
        default: begin
          r_state       <= FILL;
          r_in_ready    <= 1'b1;
          r_frame_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign frame_valid = r_frame_valid;
  assign len_err     = r_len_err;
  assign frame_count = r_frame_count;
  assign frame_data  = r_frame_data;

endmodule
